// File: rtl/uart_tx_fifo.sv
// ============================================================================
// uart_tx_fifo : byte FIFO + dispatcher feeding the UART TX control FSM.
// Optional FIFO_LEVEL / ALMOST_FULL outputs under `UART_TX_FIFO_LEVEL_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  WR_OVF,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  input  logic                  Busy
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   FIFO_LEVEL,
  output logic                  ALMOST_FULL
`endif
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [2:0]          LAST_TICK  = 3'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [2:0]            tcnt;
  state_t                state;
  logic                  push;
  logic                  pop;

  assign FULL  = (count == FULL_COUNT);
  assign EMPTY = (count == '0);
  assign push  = WR_EN && !FULL;
  assign pop   = (state == S_IDLE) && !EMPTY && !Busy;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= WR_DATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tcnt       <= '0;
      state      <= S_IDLE;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      WR_OVF     <= 1'b0;
    end else begin
      WR_OVF     <= WR_EN && FULL;
      Data_Valid <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      case (state)
        S_IDLE: begin
          if (pop) begin
            P_DATA     <= mem[rd_ptr];
            Data_Valid <= 1'b1;
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tcnt  <= '0;
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // A frame that never starts is abandoned, not re-offered.
          if (Busy)                   state <= S_WAIT_DONE;
          else if (tcnt == LAST_TICK) state <= S_IDLE;
          else                        tcnt  <= tcnt + 1'b1;
        end
        S_WAIT_DONE: begin
          if (!Busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_LEVEL_EN
  assign FIFO_LEVEL  = count;
  assign ALMOST_FULL = (count >= FULL_COUNT - 1'b1);
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// tb_uart_tx_fifo : directed self-checking bench for uart_tx_fifo.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       full, empty, wr_ovf, dv;
  logic [7:0] p_data;
  logic       force_busy = 1'b0;
  logic       model_busy = 1'b0;
  logic       model_en = 1'b0;
  logic       busy;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [3:0] fifo_level;
  logic       almost_full;
`endif

  assign busy = force_busy | model_busy;

  uart_tx_fifo dut (
    .CLK        (clk),
    .RST        (rst),
    .WR_DATA    (wr_data),
    .WR_EN      (wr_en),
    .FULL       (full),
    .EMPTY      (empty),
    .WR_OVF     (wr_ovf),
    .P_DATA     (p_data),
    .Data_Valid (dv),
    .Busy       (busy)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .FIFO_LEVEL (fifo_level),
    .ALMOST_FULL(almost_full)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch monitor plus TX model: Busy rises two cycles after a pulse, holds 11 cycles.
  logic [7:0] rx[$];
  int         rx_cyc[$];
  int         cyc = 0;
  bit         dv_in_busy = 0;
  bit         pd_moved = 0;
  logic [7:0] last_pd = 8'h00;
  int         bcnt = 0;
  bit         pend = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        last_pd = p_data;
      end else if (dv) begin
        rx.push_back(p_data);
        rx_cyc.push_back(cyc);
        if (busy) dv_in_busy = 1;
        last_pd = p_data;
      end else if (p_data !== last_pd) begin
        pd_moved = 1;
      end
      if (model_en) begin
        if (pend) begin
          model_busy = 1'b1;
          bcnt = 11;
          pend = 0;
        end else if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0) model_busy = 1'b0;
        end
        if (dv && !rst) pend = 1;
      end
    end
  end

  task automatic wait_rx(input int n, input int budget, input string tag);
    int i = 0;
    while (rx.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(rx.size() >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset held with random activity on the inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_dv_low", dv, 1'b0);
      wr_en      = 1'($urandom_range(0, 1));
      wr_data    = 8'($urandom);
      force_busy = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_pdata", p_data, 8'h00);
    check("rst_ovf", wr_ovf, 1'b0);
    wr_en = 1'b0; force_busy = 1'b0;
    rst = 1'b0;
    model_en = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_dv", 32'(rx.size()), 32'd0);

    // Single byte latency
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk); wr_en = 1'b0;
    check("single_empty_fell", empty, 1'b0);
    check("single_dv_n", dv, 1'b0);
    @(negedge clk);
    check("single_dv_n1", dv, 1'b1);
    check("single_pdata", p_data, 8'hA5);
    check("single_empty_back", empty, 1'b1);
    @(negedge clk);
    check("single_dv_n2", dv, 1'b0);
    repeat (20) @(negedge clk);

    // Ordered burst
    rx.delete(); dv_in_busy = 0; pd_moved = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'(8'h11 * (i + 1));
    end
    @(negedge clk); wr_en = 1'b0;
    wait_rx(3, 200, "burst_count");
    check("burst_b0", rx[0], 8'h11);
    check("burst_b1", rx[1], 8'h22);
    check("burst_b2", rx[2], 8'h33);
    repeat (20) @(negedge clk);
    check("burst_no_dv_in_busy", 32'(dv_in_busy), 32'd0);
    check("burst_pdata_stable", 32'(pd_moved), 32'd0);
    check("burst_total", 32'(rx.size()), 32'd3);

    // Full and overflow
    model_en = 1'b0; force_busy = 1'b1; rx.delete();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'(i);
    end
    @(negedge clk);
    check("full_set", full, 1'b1);
    wr_data = 8'hFF;
    @(negedge clk); wr_en = 1'b0;
    check("ovf_pulse", wr_ovf, 1'b1);
    @(negedge clk);
    check("ovf_single", wr_ovf, 1'b0);
    check("full_held", full, 1'b1);
    check("full_no_launch", 32'(rx.size()), 32'd0);
    force_busy = 1'b0; model_en = 1'b1;
    wait_rx(8, 400, "full_drain_count");
    for (int i = 0; i < 8; i++) check($sformatf("full_b%0d", i), rx[i], 8'(i + 1));
    repeat (30) @(negedge clk);
    check("ovf_dropped", 32'(rx.size()), 32'd8);
    check("drain_empty", empty, 1'b1);

    // Busy timeout: launch 3C, no Busy, then 4D follows after 4 wait cycles
    model_en = 1'b0; rx.delete(); rx_cyc.delete();
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h3C;
    @(negedge clk); wr_data = 8'h4D;
    @(negedge clk); wr_en = 1'b0;
    wait_rx(2, 100, "to_count");
    check("to_first", rx[0], 8'h3C);
    check("to_second", rx[1], 8'h4D);
    check("to_gap", 32'(rx_cyc[1] - rx_cyc[0]), 32'd6);
    repeat (20) @(negedge clk);
    check("to_no_repeat", 32'(rx.size()), 32'd2);

    // Reset mid-frame with bytes still queued
    model_en = 1'b1; rx.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'(8'hC1 + i);
    end
    @(negedge clk); wr_en = 1'b0;
    begin
      int k = 0;
      while (!model_busy && k < 50) begin @(negedge clk); k++; end
      check("mid_busy_seen", model_busy, 1'b1);
    end
    repeat (3) @(negedge clk);
    check("mid_queued", empty, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_full", full, 1'b0);
    check("mid_rst_dv", dv, 1'b0);
    check("mid_rst_pdata", p_data, 8'h00);
    check("mid_rst_ovf", wr_ovf, 1'b0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_no_dv_after", 32'(rx.size()), 32'd1);
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h5A;
    @(negedge clk); wr_en = 1'b0;
    wait_rx(2, 100, "mid_new_count");
    check("mid_new_byte", rx[1], 8'h5A);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and dispatcher that sits directly upstream of the UART TX control FSM. It accepts parallel bytes from the system side at any rate and queues them. It then presents them to the transmitter one frame at a time: a single-cycle `Data_Valid` pulse with a stable `P_DATA`, paced by the transmitter's registered `Busy`. It decouples bursty system writes from the serial frame rate and guarantees no byte is offered while a frame is in flight.

## Interface
Parameters:
- `DATA_WIDTH`, 8: byte width; must match the TX data path.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `ADDR_WIDTH`, log2(DEPTH) = 3: pointer width.
- `BUSY_TIMEOUT`, 4: cycles to wait for `Busy` to rise after a launch.

Ports:
- `CLK` in 1: single clock.
- `RST` in 1: asynchronous, active-high reset.
- `WR_DATA` in DATA_WIDTH: byte to enqueue.
- `WR_EN` in 1: enqueue strobe, sampled on the rising `CLK` edge.
- `FULL` out 1: high when count == DEPTH.
- `EMPTY` out 1: high when count == 0.
- `WR_OVF` out 1: one-cycle pulse when a write is dropped because the FIFO is full.
- `P_DATA` out DATA_WIDTH: registered byte offered to TX; held until the next launch.
- `Data_Valid` out 1: registered one-cycle launch pulse to the TX FSM.
- `Busy` in 1: registered busy flag from the TX FSM.

## Operation
- Storage: `DEPTH`×`DATA_WIDTH` register array; `wr_ptr` and `rd_ptr` are ADDR_WIDTH bits and wrap naturally.
- Count: `count` register is ADDR_WIDTH+1 bits. `FULL` and `EMPTY` are decoded from `count`.
- Write: when `WR_EN` is high and `FULL` is low, store `WR_DATA` at `wr_ptr` and increment `wr_ptr`. When `WR_EN` is high and `FULL` is high, drop the byte, leave the pointers unchanged and pulse `WR_OVF` the next cycle.
- Pop: occurs only on the IDLE→LAUNCH transition. `P_DATA <= mem[rd_ptr]` and `rd_ptr` increments.
- Simultaneous write and pop: `count` is unchanged. A write while `FULL` is rejected even if a pop occurs in the same cycle, because `FULL` is state-based.
- Dispatcher FSM:
  - IDLE: when `!EMPTY && !Busy`, go to LAUNCH and pop; otherwise stay.
  - LAUNCH: `Data_Valid` = 1 for exactly this cycle; always go to WAIT_BUSY.
  - WAIT_BUSY: when `Busy` = 1, go to WAIT_DONE. After BUSY_TIMEOUT cycles without `Busy`, go to IDLE; the byte counts as consumed and is not re-offered. This state uses a 3-bit timeout counter, cleared on entry.
  - WAIT_DONE: when `Busy` = 0, go to IDLE.
  - Unused encodings: go to IDLE.
- `Data_Valid` is driven from a flop (Moore, state == LAUNCH). `P_DATA` is stable from the launch edge through the whole frame.
- Reset (any time, including mid-frame):
  - Pointers, `count` and the timeout counter clear to 0; state goes to IDLE.
  - Outputs: `P_DATA` = 0, `Data_Valid` = 0, `WR_OVF` = 0, `EMPTY` = 1, `FULL` = 0.
  - Queued bytes are discarded. The array contents need not be reset.

## Timing
- Write-to-launch latency into an empty, idle FIFO: `WR_EN` sampled at edge N makes `EMPTY` fall after N. IDLE→LAUNCH occurs at edge N+1, and `Data_Valid` is high for the cycle from N+1 to N+2.
- After the last byte is popped, `EMPTY` rises after the launch edge.
- The TX FSM raises `Busy` two edges after sampling `Data_Valid`, which is within BUSY_TIMEOUT.
- Minimum gap between launches: the next launch edge is no earlier than the edge after `Busy` is sampled low in WAIT_DONE.
- Back-to-back `WR_EN` is accepted every cycle until `FULL`.

## Configuration
- `UART_TX_FIFO_LEVEL_EN` defined: adds output `FIFO_LEVEL` [ADDR_WIDTH:0] (= `count`, reset 0) and output `ALMOST_FULL` (count ≥ DEPTH-1, reset 0).
- Undefined: neither port exists; all other behaviour is identical.

## Test plan
- Reset: assert `RST` with random inputs → `EMPTY`=1, `FULL`=0, `Data_Valid`=0, `P_DATA`=0x00, `WR_OVF`=0; no `Data_Valid` while reset is held.
- Single byte: write 0xA5 at edge N with `Busy`=0 → `Data_Valid` high only in cycle N+1..N+2 with `P_DATA`=0xA5; `EMPTY` returns to 1 after N+1.
- Ordered burst: write 0x11, 0x22, 0x33 on consecutive edges; the TX model raises `Busy` 2 edges after each launch for 11 cycles → three `Data_Valid` pulses carrying 0x11, 0x22, 0x33 in order. No pulse occurs while `Busy`=1, and `P_DATA` stays constant during each frame.
- Full/overflow: hold `Busy`=1 and write 0x01..0x08 → `FULL`=1. A 9th write of 0xFF → `WR_OVF` pulses once and the byte is dropped. Release `Busy` → exactly 0x01..0x08 are delivered and pointers wrap cleanly.
- Timeout: launch 0x3C with `Busy` held 0 → the FSM returns to IDLE after 4 cycles and the next queued byte (0x4D) is launched; 0x3C is not repeated.
- Reset mid-frame: 3 bytes queued, in WAIT_DONE, assert `RST` → all outputs at reset values; after release, no `Data_Valid` occurs until a new write.
